median_window_feeder: RTL

Producer side of the median-filter datapath. It accepts a raster-order 8-bit pixel stream and buffers two full image lines plus a 3-column shift window. For every interior pixel it emits one registered 3×3 neighbourhood, which the downstream column/row sorters reduce to the median. Border pixels (first two rows and first two columns of the window's trailing corner) produce no output.

---
 rtl/median_window_feeder.sv | 101 ++++++++++
 1 files changed

// File: rtl/median_window_feeder.sv
// Raster-stream 3x3 window generator feeding the median column/row sorters.
// Two line buffers plus a two-column shift window yield one registered neighbourhood per interior pixel.
module median_window_feeder #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         pix_in,
    input  logic                      pix_valid,
    input  logic                      sof,
    output logic [DATA_W-1:0]         w0,
    output logic [DATA_W-1:0]         w1,
    output logic [DATA_W-1:0]         w2,
    output logic [DATA_W-1:0]         w3,
    output logic [DATA_W-1:0]         w4,
    output logic [DATA_W-1:0]         w5,
    output logic [DATA_W-1:0]         w6,
    output logic [DATA_W-1:0]         w7,
    output logic [DATA_W-1:0]         w8,
    output logic                      win_valid,
    output logic [$clog2(IMG_W)-1:0]  cx,
    output logic [$clog2(IMG_H)-1:0]  cy,
    output logic                      frame_done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    // Handshake: pix_valid is a pure valid with no ready; every cycle it is high
    // pix_in is consumed, and win_valid is a one-cycle output pulse with no stall.

    logic [XW-1:0] x, px, nx;
    logic [YW-1:0] y, py, ny;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] new_t, new_m;
    logic [DATA_W-1:0] mid_t, mid_m, mid_b;
    logic [DATA_W-1:0] rgt_t, rgt_m, rgt_b;
    logic interior, last_pix;

    // sof relocates the accepted pixel to the frame origin before anything else uses x/y.
    assign px       = sof ? '0 : x;
    assign py       = sof ? '0 : y;
    assign new_t    = lb1[px];
    assign new_m    = lb0[px];
    assign interior = (px >= XW'(2)) && (py >= YW'(2));
    assign last_pix = (px == X_LAST) && (py == Y_LAST);

    always_comb begin
        nx = px + XW'(1);
        ny = py;
        if (px == X_LAST) begin
            nx = '0;
            ny = (py == Y_LAST) ? '0 : py + YW'(1);
        end
    end

    // Line buffer storage is never reset; the interior rule hides stale rows.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[px] <= lb0[px];
            lb0[px] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;  y <= '0;
            mid_t <= '0; mid_m <= '0; mid_b <= '0;
            rgt_t <= '0; rgt_m <= '0; rgt_b <= '0;
            w0 <= '0; w1 <= '0; w2 <= '0;
            w3 <= '0; w4 <= '0; w5 <= '0;
            w6 <= '0; w7 <= '0; w8 <= '0;
            cx <= '0; cy <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                x <= nx;
                y <= ny;
                mid_t <= rgt_t; mid_m <= rgt_m; mid_b <= rgt_b;
                rgt_t <= new_t; rgt_m <= new_m; rgt_b <= pix_in;
                if (interior) begin
                    // Post-shift view: old middle is left, old right is middle, new column is right.
                    w0 <= mid_t; w1 <= rgt_t; w2 <= new_t;
                    w3 <= mid_m; w4 <= rgt_m; w5 <= new_m;
                    w6 <= mid_b; w7 <= rgt_b; w8 <= pix_in;
                    cx <= px - XW'(1);
                    cy <= py - YW'(1);
                    win_valid  <= 1'b1;
                    frame_done <= last_pix;
                end
            end
        end
    end
endmodule
